// File: rtl/alu_sequencer.sv
// Sequences one ALU operation per request: latch A/B/F/Op, read Y/F, return the result on a response channel.
// Latency 5-7 cycles (1 for illegal op); req_ready low from accept until the response handshake; resp held until resp_ready.
module alu_sequencer #(
    parameter int WIDTH   = 16,
    parameter int FLAGS_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic               req_load_flags,
    input  logic [FLAGS_W-1:0] req_flags,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_y,
    output logic [FLAGS_W-1:0] resp_flags,
    output logic               resp_err,
    output logic [3:0]         alu_com,
    output logic [WIDTH-1:0]   alu_dout,
    input  logic [WIDTH-1:0]   alu_din
);

    typedef enum logic [2:0] {IDLE, LA, LB, LF, LOP, OY, OF, RESP} state_t;

    localparam logic [3:0] COM_NOP = 4'h0;
    localparam logic [3:0] COM_LA  = 4'h1;
    localparam logic [3:0] COM_LB  = 4'h2;
    localparam logic [3:0] COM_LF  = 4'h3;
    localparam logic [3:0] COM_LOP = 4'h4;
    localparam logic [3:0] COM_OY  = 4'h5;
    localparam logic [3:0] COM_OF  = 4'h6;

    localparam logic [3:0] OP_CMP  = 4'h3;
    localparam logic [3:0] OP_INC  = 4'h4;
    localparam logic [3:0] OP_DEC  = 4'h5;
    localparam logic [3:0] OP_LSH  = 4'hB;
    localparam logic [3:0] OP_RSH  = 4'hC;
    localparam logic [3:0] OP_LAST = 4'hC;

    state_t               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 lf_q, lf_d;
    logic [FLAGS_W-1:0]   flags_q, flags_d;
    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]     resp_y_q, resp_y_d;
    logic [FLAGS_W-1:0]   resp_flags_q, resp_flags_d;
    logic                 resp_err_q, resp_err_d;
    logic [3:0]           alu_com_q, alu_com_d;
    logic [WIDTH-1:0]     alu_dout_q, alu_dout_d;

    function automatic logic is_unary(input logic [3:0] op);
        return (op == OP_INC) || (op == OP_DEC) || (op == OP_LSH) || (op == OP_RSH);
    endfunction

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        lf_d         = lf_q;
        flags_d      = flags_q;
        resp_y_d     = resp_y_q;
        resp_flags_d = resp_flags_q;
        resp_err_d   = resp_err_q;
        alu_com_d    = COM_NOP;
        alu_dout_d   = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d         = req_op;
                    a_d          = req_a;
                    b_d          = req_b;
                    lf_d         = req_load_flags;
                    flags_d      = req_flags;
                    resp_y_d     = '0;
                    resp_flags_d = '0;
                    resp_err_d   = (req_op > OP_LAST);
                    state_d      = (req_op > OP_LAST) ? RESP : LA;
                end
            end
            LA:      state_d = is_unary(op_q) ? (lf_q ? LF : LOP) : LB;
            LB:      state_d = lf_q ? LF : LOP;
            LF:      state_d = LOP;
            LOP:     state_d = (op_q == OP_CMP) ? OF : OY;
            OY: begin
                resp_y_d = alu_din;
                state_d  = OF;
            end
            OF: begin
                resp_flags_d = alu_din[FLAGS_W-1:0];
                resp_err_d   = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Command outputs are registered, so they are decoded from the state being entered.
        case (state_d)
            LA: begin
                alu_com_d  = COM_LA;
                alu_dout_d = a_d;
            end
            LB: begin
                alu_com_d  = COM_LB;
                alu_dout_d = b_d;
            end
            LF: begin
                alu_com_d  = COM_LF;
                alu_dout_d = {{(WIDTH-FLAGS_W){1'b0}}, flags_d};
            end
            LOP: begin
                alu_com_d  = COM_LOP;
                alu_dout_d = {{(WIDTH-4){1'b0}}, op_d};
            end
            OY:      alu_com_d = COM_OY;
            OF:      alu_com_d = COM_OF;
            default: alu_com_d = COM_NOP;
        endcase

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            lf_q         <= 1'b0;
            flags_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_y_q     <= '0;
            resp_flags_q <= '0;
            resp_err_q   <= 1'b0;
            alu_com_q    <= COM_NOP;
            alu_dout_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            lf_q         <= lf_d;
            flags_q      <= flags_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_y_q     <= resp_y_d;
            resp_flags_q <= resp_flags_d;
            resp_err_q   <= resp_err_d;
            alu_com_q    <= alu_com_d;
            alu_dout_q   <= alu_dout_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_y     = resp_y_q;
    assign resp_flags = resp_flags_q;
    assign resp_err   = resp_err_q;
    assign alu_com    = alu_com_q;
    assign alu_dout   = alu_dout_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU responder, command-trace monitor and result scoreboard.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_load_flags;
    logic [7:0]  req_flags;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_y;
    logic [7:0]  resp_flags;
    logic        resp_err;
    logic [3:0]  alu_com;
    logic [15:0] alu_dout;
    logic [15:0] alu_din;

    logic [15:0] model_y;
    logic [7:0]  model_flags;

    typedef struct packed {
        logic [15:0] y;
        logic [7:0]  f;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  trace_com[$];
    logic [15:0] trace_dout[$];
    logic [3:0]  exp_com[6];
    logic [15:0] exp_dout[6];

    int n_cmp = 0;
    int n_err = 0;

    alu_sequencer #(.WIDTH(16), .FLAGS_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_load_flags(req_load_flags), .req_flags(req_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
        .resp_flags(resp_flags), .resp_err(resp_err),
        .alu_com(alu_com), .alu_dout(alu_dout), .alu_din(alu_din)
    );

    always #5 clk = ~clk;

    // ALU responder: Y and flags only on output commands, junk otherwise.
    assign alu_din = (alu_com == 4'd5) ? model_y :
                     (alu_com == 4'd6) ? {8'h00, model_flags} : 16'hDEAD;

    always @(negedge clk) begin
        if (alu_com !== 4'd0) begin
            trace_com.push_back(alu_com);
            trace_dout.push_back(alu_dout);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string name, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic lf, input logic [7:0] fl,
                          input logic [15:0] my, input logic [7:0] mf,
                          input exp_t e, input int lat, input int n_cmds, input int hold);
        int   cnt;
        logic rdy_bad;
        exp_t got;
        @(negedge clk);
        trace_com.delete();
        trace_dout.delete();
        model_y        = my;
        model_flags    = mf;
        req_op         = op;
        req_a          = a;
        req_b          = b;
        req_load_flags = lf;
        req_flags      = fl;
        req_valid      = 1'b1;
        chk({name, "_req_ready"}, req_ready, 1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid      = 1'b0;
        req_op         = 4'hF;
        req_a          = ~a;
        req_b          = ~b;
        req_load_flags = ~lf;
        req_flags      = ~fl;
        rdy_bad = 1'b0;
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (resp_valid) break;
            if (req_ready !== 1'b0) rdy_bad = 1'b1;
        end
        chk({name, "_latency"}, cnt, lat);
        chk({name, "_busy_rdy"}, rdy_bad, 0);
        got = exp_q.pop_front();
        if (resp_valid !== 1'b1) return;
        chk({name, "_y"}, resp_y, got.y);
        chk({name, "_flags"}, resp_flags, got.f);
        chk({name, "_err"}, resp_err, got.e);
        chk({name, "_ncmd"}, trace_com.size(), n_cmds);
        for (int i = 0; i < n_cmds && i < trace_com.size(); i++) begin
            chk({name, "_com"}, trace_com[i], exp_com[i]);
            if (exp_com[i] <= 4'd4) chk({name, "_dout"}, trace_dout[i], exp_dout[i]);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold"}, {resp_valid, resp_err, req_ready, resp_y, resp_flags},
                {1'b1, got.e, 1'b0, got.y, got.f});
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk({name, "_done"}, {resp_valid, req_ready}, 2'b01);
    endtask

    task automatic run_to_com(input logic [3:0] com);
        int cnt;
        @(negedge clk);
        model_y = 16'h5555; model_flags = 8'h00;
        req_op = 4'h0; req_a = 16'd3; req_b = 16'd4;
        req_load_flags = 1'b0; req_flags = 8'h00; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (alu_com !== com && cnt < 10);
        chk("reach_com", alu_com, com);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b1; req_op = 4'h0; req_a = 16'h1111; req_b = 16'h2222;
        req_load_flags = 1'b0; req_flags = 8'h00; resp_ready = 1'b0;
        model_y = 16'h0; model_flags = 8'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {req_ready, resp_valid, resp_err, alu_com, alu_dout, resp_y, resp_flags},
            {1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 8'h0});
        chk("rst_no_cmd", trace_com.size(), 0);
        rst_n = 1'b1;
        req_valid = 1'b0;

        exp_com  = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd0};
        exp_dout = '{16'h0003, 16'h0004, 16'h0000, 16'h0, 16'h0, 16'h0};
        do_req("add", 4'h0, 16'h0003, 16'h0004, 1'b0, 8'h00, 16'h0007, 8'h00,
               '{y: 16'h0007, f: 8'h00, e: 1'b0}, 6, 5, 0);

        exp_com  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        exp_dout = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'h0, 16'h0};
        do_req("adc", 4'h1, 16'hFFFF, 16'h0000, 1'b1, 8'h01, 16'h0000, 8'h03,
               '{y: 16'h0000, f: 8'h03, e: 1'b0}, 7, 6, 0);

        exp_com  = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd0, 4'd0};
        exp_dout = '{16'h00FF, 16'h0004, 16'h0, 16'h0, 16'h0, 16'h0};
        do_req("inc", 4'h4, 16'h00FF, 16'h1234, 1'b0, 8'h00, 16'h0100, 8'h00,
               '{y: 16'h0100, f: 8'h00, e: 1'b0}, 5, 4, 0);

        exp_com  = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd0, 4'd0};
        exp_dout = '{16'h0005, 16'h0005, 16'h0003, 16'h0, 16'h0, 16'h0};
        do_req("cmp", 4'h3, 16'h0005, 16'h0005, 1'b0, 8'h00, 16'hBEEF, 8'h04,
               '{y: 16'h0000, f: 8'h04, e: 1'b0}, 5, 4, 0);

        do_req("illegal", 4'hE, 16'hAAAA, 16'h5555, 1'b1, 8'hFF, 16'h1234, 8'h77,
               '{y: 16'h0000, f: 8'h00, e: 1'b1}, 1, 0, 4);

        // Unary op with flag preload takes the LA -> LF path.
        exp_com  = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0};
        exp_dout = '{16'h0100, 16'h0001, 16'h0005, 16'h0, 16'h0, 16'h0};
        do_req("dec_lf", 4'h5, 16'h0100, 16'h9999, 1'b1, 8'h01, 16'h00FF, 8'h20,
               '{y: 16'h00FF, f: 8'h20, e: 1'b0}, 6, 5, 0);

        run_to_com(4'd5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_oy", {alu_com, resp_valid, req_ready, resp_y}, {4'h0, 1'b0, 1'b1, 16'h0});
        rst_n = 1'b1;
        trace_com.delete();
        repeat (3) @(negedge clk);
        chk("rst_oy_quiet", trace_com.size(), 0);

        run_to_com(4'd6);
        chk("y_before_rst", resp_y, 16'h5555);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_of", {alu_com, resp_valid, resp_y, resp_flags}, {4'h0, 1'b0, 16'h0, 8'h0});
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
